decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter RV32E, default 0, which when set to 1 makes register indices 16-31 illegal.
REQ-002 The block SHALL have parameter EN_M, default 0, which when set to 1 makes M-extension ops legal.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the illegal-counter width.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low (0 = reset).
REQ-006 in_valid  in  1  upstream instruction valid.
REQ-007 in_ready  out  1  block accepts the instruction this cycle.
REQ-008 in_inst  in  32  RV32 instruction word.
REQ-009 in_pc  in  32  PC of in_inst.
REQ-010 flush  in  1  synchronous kill of the held and incoming instruction.
REQ-011 out_valid  out  1  registered decoded instruction valid.
REQ-012 out_ready  in  1  downstream accepts.
REQ-013 out_pc  out  32  PC of the held instruction.
REQ-014 rs1, rs2, rd  out  5 each  register indices.
REQ-015 alu_ctrl  out  5  ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9; M ops = 16+fun3.
REQ-016 reg_w_ctrl, alu_dataB_sel, pc_add_sel, reg_w_data_sel, mem_read_ctrl, mem_write_ctrl  out  1 each  control flags with the existing decoder meanings.
REQ-017 jal_or_jalrF  out  2  1 = JAL, 2 = JALR, otherwise 0.
REQ-018 alu_op  out  2  00 = load/store/jump, 01 = branch, 10 = OP/OP-IMM, 11 = LUI/AUIPC.
REQ-019 imm_exten  out  32  sign-extended I/S/B/U/J immediate.
REQ-020 illegal  out  1  held instruction is illegal.
REQ-021 illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions.

Function
REQ-022 The block SHALL implement a one-entry output register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-023 A transfer SHALL occur when in_valid && in_ready, and all outputs SHALL reflect the decoded in_inst/in_pc the following cycle, giving a latency of 1.
REQ-024 in_ready SHALL equal !flush && (!out_valid || out_ready) && !hazard, computed combinationally.
REQ-025 hazard SHALL be asserted when out_valid && mem_read_ctrl && rd!=0 && ((uses_rs1 && in rs1==rd) || (uses_rs2 && in rs2==rd)).
  - uses_rs1: every opcode except LUI, AUIPC and JAL.
  - uses_rs2: OP, STORE and BRANCH.
REQ-026 When a hazard is present and out_ready=1, the load SHALL leave, the state SHALL go to EMPTY for exactly one cycle (a bubble), and the dependent instruction SHALL be accepted in the next cycle.
REQ-027 In FULL with out_ready=0, every output SHALL hold its value.
REQ-028 In FULL with out_ready=1 and a transfer, the block SHALL stay FULL with the new instruction (back-to-back, no bubble).
REQ-029 In FULL with out_ready=1 and no transfer, the block SHALL go to EMPTY.
REQ-030 flush=1 SHALL force EMPTY next cycle, accept nothing, and leave illegal_cnt unchanged; flush SHALL take priority over all other events.
REQ-031 An instruction SHALL be illegal when any of the following holds:
  - its opcode is not one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP;
  - it has an invalid fun3/fun7 combination;
  - it is an M op while EN_M=0;
  - RV32E=1 and any used index is >= 16;
  - inst[1:0] != 11.
REQ-032 An illegal instruction SHALL be held with illegal=1 and with reg_w_ctrl, mem_read_ctrl, mem_write_ctrl and jal_or_jalrF all 0.
REQ-033 illegal_cnt SHALL increment by 1 on each accepted illegal instruction and SHALL saturate at all-ones.
REQ-034 JALR SHALL use an I-immediate with jal_or_jalrF=2, pc_add_sel=1 and reg_w_ctrl=1.
REQ-035 Branches SHALL use a B-immediate with bit 0 = 0.
REQ-036 Shift-immediates with inst[31:25] other than 0000000, or 0100000 for SRAI, SHALL be illegal.

Reset
REQ-037 While reset=0, the block SHALL immediately force out_valid=0, all decoded outputs and out_pc to 0, illegal_cnt to 0, and the state to EMPTY.
REQ-038 While reset=0, in_ready SHALL be 0.
REQ-039 Assertion of reset mid-transfer SHALL discard the held instruction.
REQ-040 The block SHALL resume at the first clk edge after reset returns to 1.

Verification
REQ-041 Accept 0x00AA8C33 (add x24,x21,x10) with out_ready=1 -> next cycle out_valid=1, rd=24, rs1=21, rs2=10, alu_ctrl=0, reg_w_ctrl=1, alu_op=10, illegal=0.
REQ-042 Accept 0x00000C67 (jalr x24,0(x0)) -> jal_or_jalrF=2, imm_exten=0, rd=24, pc_add_sel=1.
REQ-043 Send 0x0000A283 (lw x5) then 0x00028333 (add x6,x5,x0) with out_ready=1 -> in_ready=0 for one cycle, exactly one bubble, then the add is held; without the dependency, the two instructions SHALL pass back-to-back.
REQ-044 Send 0x023100B3 (mul) -> with EN_M=0, illegal=1 and illegal_cnt 0->1; with EN_M=1, alu_ctrl=16 and illegal=0.
REQ-045 Apply out_ready=0 for 3 cycles while FULL -> outputs stable, in_ready=0; then flush=1 -> out_valid=0 next cycle and illegal_cnt unchanged.
REQ-046 Assert reset=0 asynchronously between clock edges while FULL -> out_valid=0 immediately; preload illegal_cnt to 0xFFFF with CNT_W=16 and accept an illegal instruction -> illegal_cnt stays at 0xFFFF.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I/E(+M) decode stage with a one-entry output register, load-use hazard stall,
// illegal-instruction detection and a saturating illegal counter.
//  state | meaning
//  EMPTY | no decoded instruction held, o_out_valid = 0
//  FULL  | decoded instruction held, o_out_valid = 1
module decode_stage #(
   parameter int RV32E = 0,
   parameter int EN_M  = 0,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [31:0]      i_in_inst,
   input  logic [31:0]      i_in_pc,
   input  logic             i_flush,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [31:0]      o_out_pc,
   output logic [4:0]       o_rs1,
   output logic [4:0]       o_rs2,
   output logic [4:0]       o_rd,
   output logic [4:0]       o_alu_ctrl,
   output logic             o_reg_w_ctrl,
   output logic             o_alu_dataB_sel,
   output logic             o_pc_add_sel,
   output logic             o_reg_w_data_sel,
   output logic             o_mem_read_ctrl,
   output logic             o_mem_write_ctrl,
   output logic [1:0]       o_jal_or_jalrF,
   output logic [1:0]       o_alu_op,
   output logic [31:0]      o_imm_exten,
   output logic             o_illegal,
   output logic [CNT_W-1:0] o_illegal_cnt
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t           r_state;
   logic [4:0]       r_rs1, r_rs2, r_rd, r_alu_ctrl;
   logic             r_reg_w, r_datab, r_pc_add, r_wdata_sel, r_mem_rd, r_mem_wr, r_illegal;
   logic [1:0]       r_jal, r_alu_op;
   logic [31:0]      r_pc, r_imm;
   logic [CNT_W-1:0] r_cnt;

   logic [6:0]  w_opc, w_f7;
   logic [2:0]  w_f3;
   logic [4:0]  w_rs1, w_rs2, w_rd, w_alu_ctrl;
   logic        w_uses_rs1, w_uses_rs2, w_uses_rd, w_known, w_bad_fn, w_is_m, w_bad_reg;
   logic        w_illegal, w_reg_w, w_datab, w_pc_add, w_wdata_sel, w_mem_rd, w_mem_wr;
   logic [1:0]  w_jal, w_alu_op;
   logic [31:0] w_imm;
   logic        w_out_valid, w_hazard, w_in_ready, w_xfer;

   function automatic logic [4:0] base_alu(input logic [2:0] f3);
      case (f3)
         3'b000:  base_alu = 5'd0;
         3'b001:  base_alu = 5'd2;
         3'b010:  base_alu = 5'd3;
         3'b011:  base_alu = 5'd4;
         3'b100:  base_alu = 5'd5;
         3'b101:  base_alu = 5'd6;
         3'b110:  base_alu = 5'd8;
         default: base_alu = 5'd9;
      endcase
   endfunction

   assign w_opc = i_in_inst[6:0];
   assign w_rd  = i_in_inst[11:7];
   assign w_f3  = i_in_inst[14:12];
   assign w_rs1 = i_in_inst[19:15];
   assign w_rs2 = i_in_inst[24:20];
   assign w_f7  = i_in_inst[31:25];

   assign w_uses_rs1 = !(w_opc == OPC_LUI || w_opc == OPC_AUIPC || w_opc == OPC_JAL);
   assign w_uses_rs2 = (w_opc == OPC_OP || w_opc == OPC_STORE || w_opc == OPC_BRANCH);

   always_comb begin
      w_known     = 1'b1;
      w_bad_fn    = 1'b0;
      w_is_m      = 1'b0;
      w_uses_rd   = 1'b0;
      w_alu_ctrl  = 5'd0;
      w_reg_w     = 1'b0;
      w_datab     = 1'b0;
      w_pc_add    = 1'b0;
      w_wdata_sel = 1'b0;
      w_mem_rd    = 1'b0;
      w_mem_wr    = 1'b0;
      w_jal       = 2'd0;
      w_alu_op    = 2'b00;
      w_imm       = 32'd0;
      case (w_opc)
         OPC_LUI, OPC_AUIPC: begin
            w_uses_rd = 1'b1; w_reg_w = 1'b1; w_datab = 1'b1; w_alu_op = 2'b11;
            w_imm = {i_in_inst[31:12], 12'd0};
         end
         OPC_JAL: begin
            w_uses_rd = 1'b1; w_reg_w = 1'b1; w_datab = 1'b1; w_jal = 2'd1;
            w_imm = {{11{i_in_inst[31]}}, i_in_inst[31], i_in_inst[19:12], i_in_inst[20],
                     i_in_inst[30:21], 1'b0};
         end
         OPC_JALR: begin
            w_uses_rd = 1'b1; w_reg_w = 1'b1; w_datab = 1'b1; w_jal = 2'd2; w_pc_add = 1'b1;
            w_imm = {{20{i_in_inst[31]}}, i_in_inst[31:20]};
            w_bad_fn = (w_f3 != 3'b000);
         end
         OPC_BRANCH: begin
            w_alu_op = 2'b01;
            w_imm = {{19{i_in_inst[31]}}, i_in_inst[31], i_in_inst[7], i_in_inst[30:25],
                     i_in_inst[11:8], 1'b0};
            w_alu_ctrl = (w_f3[2:1] == 2'b00) ? 5'd1 : (w_f3[1] ? 5'd4 : 5'd3);
            w_bad_fn = (w_f3[2:1] == 2'b01);
         end
         OPC_LOAD: begin
            w_uses_rd = 1'b1; w_reg_w = 1'b1; w_datab = 1'b1; w_mem_rd = 1'b1; w_wdata_sel = 1'b1;
            w_imm = {{20{i_in_inst[31]}}, i_in_inst[31:20]};
            w_bad_fn = (w_f3 == 3'b011) || (w_f3[2:1] == 2'b11);
         end
         OPC_STORE: begin
            w_datab = 1'b1; w_mem_wr = 1'b1;
            w_imm = {{20{i_in_inst[31]}}, i_in_inst[31:25], i_in_inst[11:7]};
            w_bad_fn = w_f3[2] || (w_f3[1:0] == 2'b11);
         end
         OPC_OPIMM: begin
            w_uses_rd = 1'b1; w_reg_w = 1'b1; w_datab = 1'b1; w_alu_op = 2'b10;
            w_imm = {{20{i_in_inst[31]}}, i_in_inst[31:20]};
            w_alu_ctrl = base_alu(w_f3);
            // shift-immediates reuse the funct7 field as a qualifier
            if (w_f3 == 3'b001) w_bad_fn = (w_f7 != 7'b0000000);
            if (w_f3 == 3'b101) begin
               if (w_f7 == 7'b0100000) w_alu_ctrl = 5'd7;
               else w_bad_fn = (w_f7 != 7'b0000000);
            end
         end
         OPC_OP: begin
            w_uses_rd = 1'b1; w_reg_w = 1'b1; w_alu_op = 2'b10;
            if (w_f7 == 7'b0000001) begin
               w_is_m = 1'b1; w_alu_ctrl = {2'b10, w_f3};
            end else if (w_f7 == 7'b0000000) begin
               w_alu_ctrl = base_alu(w_f3);
            end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
               w_alu_ctrl = 5'd1;
            end else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) begin
               w_alu_ctrl = 5'd7;
            end else begin
               w_bad_fn = 1'b1;
            end
         end
         default: w_known = 1'b0;
      endcase
   end

   assign w_bad_reg = (RV32E != 0) && ((w_uses_rd && w_rd[4]) || (w_uses_rs1 && w_rs1[4]) ||
                                       (w_uses_rs2 && w_rs2[4]));
   assign w_illegal = !w_known || w_bad_fn || (w_is_m && (EN_M == 0)) || w_bad_reg ||
                      (i_in_inst[1:0] != 2'b11);

   assign w_out_valid = (r_state == FULL);
   // r_mem_rd is already cleared for illegal loads, so they never stall
   assign w_hazard = w_out_valid && r_mem_rd && (r_rd != 5'd0) &&
                     ((w_uses_rs1 && (w_rs1 == r_rd)) || (w_uses_rs2 && (w_rs2 == r_rd)));
   assign w_in_ready = i_rst_n && !i_flush && (!w_out_valid || i_out_ready) && !w_hazard;
   assign w_xfer     = i_in_valid && w_in_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= EMPTY;
         r_pc <= '0; r_rs1 <= '0; r_rs2 <= '0; r_rd <= '0; r_alu_ctrl <= '0;
         r_reg_w <= 1'b0; r_datab <= 1'b0; r_pc_add <= 1'b0; r_wdata_sel <= 1'b0;
         r_mem_rd <= 1'b0; r_mem_wr <= 1'b0; r_jal <= '0; r_alu_op <= '0;
         r_imm <= '0; r_illegal <= 1'b0; r_cnt <= '0;
      end else if (i_flush) begin
         r_state <= EMPTY;
      end else if (w_xfer) begin
         r_state     <= FULL;
         r_pc        <= i_in_pc;
         r_rs1       <= w_rs1;
         r_rs2       <= w_rs2;
         r_rd        <= w_rd;
         r_alu_ctrl  <= w_alu_ctrl;
         r_datab     <= w_datab;
         r_pc_add    <= w_pc_add;
         r_wdata_sel <= w_wdata_sel;
         r_alu_op    <= w_alu_op;
         r_imm       <= w_imm;
         r_illegal   <= w_illegal;
         r_reg_w     <= w_reg_w && !w_illegal;
         r_mem_rd    <= w_mem_rd && !w_illegal;
         r_mem_wr    <= w_mem_wr && !w_illegal;
         r_jal       <= w_illegal ? 2'd0 : w_jal;
         if (w_illegal && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
      end else if (r_state == FULL && i_out_ready) begin
         r_state <= EMPTY;
      end
   end

   assign o_in_ready       = w_in_ready;
   assign o_out_valid      = w_out_valid;
   assign o_out_pc         = r_pc;
   assign o_rs1            = r_rs1;
   assign o_rs2            = r_rs2;
   assign o_rd             = r_rd;
   assign o_alu_ctrl       = r_alu_ctrl;
   assign o_reg_w_ctrl     = r_reg_w;
   assign o_alu_dataB_sel  = r_datab;
   assign o_pc_add_sel     = r_pc_add;
   assign o_reg_w_data_sel = r_wdata_sel;
   assign o_mem_read_ctrl  = r_mem_rd;
   assign o_mem_write_ctrl = r_mem_wr;
   assign o_jal_or_jalrF   = r_jal;
   assign o_alu_op         = r_alu_op;
   assign o_imm_exten      = r_imm;
   assign o_illegal        = r_illegal;
   assign o_illegal_cnt    = r_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a default instance plus an RV32E/M instance with a
// 2-bit counter so saturation is reachable quickly.
module tb_decode_stage;

   logic        clk, rst_n, rst_n_m;
   logic        in_valid, in_valid_m, flush, out_ready;
   logic [31:0] in_inst, in_pc;

   logic        in_ready, out_valid, reg_w, datab, pc_add, wdata_sel, mem_rd, mem_wr, illegal;
   logic [31:0] out_pc, imm;
   logic [4:0]  rs1, rs2, rd, alu_ctrl;
   logic [1:0]  jal, alu_op;
   logic [15:0] cnt;

   logic        in_ready_m, out_valid_m, reg_w_m, datab_m, pc_add_m, wdata_sel_m, mem_rd_m;
   logic        mem_wr_m, illegal_m;
   logic [31:0] out_pc_m, imm_m;
   logic [4:0]  rs1_m, rs2_m, rd_m, alu_ctrl_m;
   logic [1:0]  jal_m, alu_op_m;
   logic [1:0]  cnt_m;

   int n_cmp = 0;
   int n_err = 0;

   decode_stage u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_in_inst(in_inst), .i_in_pc(in_pc), .i_flush(flush), .o_out_valid(out_valid),
      .i_out_ready(out_ready), .o_out_pc(out_pc), .o_rs1(rs1), .o_rs2(rs2), .o_rd(rd),
      .o_alu_ctrl(alu_ctrl), .o_reg_w_ctrl(reg_w), .o_alu_dataB_sel(datab),
      .o_pc_add_sel(pc_add), .o_reg_w_data_sel(wdata_sel), .o_mem_read_ctrl(mem_rd),
      .o_mem_write_ctrl(mem_wr), .o_jal_or_jalrF(jal), .o_alu_op(alu_op),
      .o_imm_exten(imm), .o_illegal(illegal), .o_illegal_cnt(cnt)
   );

   decode_stage #(.RV32E(1), .EN_M(1), .CNT_W(2)) u_dut_m (
      .i_clk(clk), .i_rst_n(rst_n_m), .i_in_valid(in_valid_m), .o_in_ready(in_ready_m),
      .i_in_inst(in_inst), .i_in_pc(in_pc), .i_flush(flush), .o_out_valid(out_valid_m),
      .i_out_ready(out_ready), .o_out_pc(out_pc_m), .o_rs1(rs1_m), .o_rs2(rs2_m), .o_rd(rd_m),
      .o_alu_ctrl(alu_ctrl_m), .o_reg_w_ctrl(reg_w_m), .o_alu_dataB_sel(datab_m),
      .o_pc_add_sel(pc_add_m), .o_reg_w_data_sel(wdata_sel_m), .o_mem_read_ctrl(mem_rd_m),
      .o_mem_write_ctrl(mem_wr_m), .o_jal_or_jalrF(jal_m), .o_alu_op(alu_op_m),
      .o_imm_exten(imm_m), .o_illegal(illegal_m), .o_illegal_cnt(cnt_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; rst_n_m = 1'b0;
      in_valid = 1'b1; in_valid_m = 1'b0; flush = 1'b0; out_ready = 1'b1;
      in_inst = 32'h00AA8C33; in_pc = 32'h100;
      #12;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_cnt", 32'(cnt), 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_m_out_valid", 32'(out_valid_m), 0);
      #5 rst_n = 1'b1; rst_n_m = 1'b1;
      #1 chk("add_in_ready", 32'(in_ready), 1);
      tick();
      chk("add_valid", 32'(out_valid), 1);
      chk("add_rd", 32'(rd), 24);
      chk("add_rs1", 32'(rs1), 21);
      chk("add_rs2", 32'(rs2), 10);
      chk("add_alu_ctrl", 32'(alu_ctrl), 0);
      chk("add_reg_w", 32'(reg_w), 1);
      chk("add_alu_op", 32'(alu_op), 2);
      chk("add_illegal", 32'(illegal), 0);
      chk("add_pc", out_pc, 32'h100);

      in_inst = 32'h00000C67; in_pc = 32'h104;
      #1 chk("b2b_in_ready", 32'(in_ready), 1);
      tick();
      chk("jalr_jal", 32'(jal), 2);
      chk("jalr_imm", imm, 0);
      chk("jalr_rd", 32'(rd), 24);
      chk("jalr_pc_add", 32'(pc_add), 1);
      chk("jalr_reg_w", 32'(reg_w), 1);
      chk("jalr_pc", out_pc, 32'h104);

      in_inst = 32'h0000A283; in_pc = 32'h108;
      tick();
      chk("lw_mem_rd", 32'(mem_rd), 1);
      chk("lw_rd", 32'(rd), 5);
      chk("lw_wdata_sel", 32'(wdata_sel), 1);
      in_inst = 32'h00028333; in_pc = 32'h10C;
      #1 chk("hazard_in_ready", 32'(in_ready), 0);
      tick();
      chk("bubble_valid", 32'(out_valid), 0);
      chk("bubble_in_ready", 32'(in_ready), 1);
      tick();
      chk("dep_add_valid", 32'(out_valid), 1);
      chk("dep_add_rd", 32'(rd), 6);
      chk("dep_add_pc", out_pc, 32'h10C);

      in_inst = 32'h0000A283; in_pc = 32'h110;
      tick();
      in_inst = 32'h00008333; in_pc = 32'h114;
      #1 chk("nodep_in_ready", 32'(in_ready), 1);
      tick();
      chk("nodep_valid", 32'(out_valid), 1);
      chk("nodep_pc", out_pc, 32'h114);

      in_inst = 32'h023100B3; in_pc = 32'h118;
      chk("mul_cnt_before", 32'(cnt), 0);
      tick();
      chk("mul_illegal", 32'(illegal), 1);
      chk("mul_cnt", 32'(cnt), 1);
      chk("mul_reg_w", 32'(reg_w), 0);
      chk("mul_mem", 32'({mem_rd, mem_wr, jal}), 0);

      out_ready = 1'b0; in_inst = 32'h00AA8C33; in_pc = 32'h11C;
      for (int i = 0; i < 3; i++) begin
         #1 chk("hold_in_ready", 32'(in_ready), 0);
         tick();
         chk("hold_valid", 32'(out_valid), 1);
         chk("hold_pc", out_pc, 32'h118);
         chk("hold_rd", 32'(rd), 1);
      end
      flush = 1'b1; out_ready = 1'b1; in_inst = 32'hFFFFFFFF;
      #1 chk("flush_in_ready", 32'(in_ready), 0);
      tick();
      chk("flush_valid", 32'(out_valid), 0);
      chk("flush_cnt", 32'(cnt), 1);
      flush = 1'b0; in_valid = 1'b0;
      tick();
      chk("post_flush_valid", 32'(out_valid), 0);

      in_valid = 1'b1; in_inst = 32'h40315093; in_pc = 32'h120;
      tick();
      chk("srai_alu_ctrl", 32'(alu_ctrl), 7);
      chk("srai_illegal", 32'(illegal), 0);
      chk("srai_imm", imm, 32'h403);
      chk("srai_datab", 32'(datab), 1);
      in_inst = 32'h42315093;
      tick();
      chk("bad_shift_illegal", 32'(illegal), 1);
      chk("bad_shift_reg_w", 32'(reg_w), 0);
      chk("bad_shift_cnt", 32'(cnt), 2);
      in_inst = 32'h0000007F;
      tick();
      chk("bad_opc_illegal", 32'(illegal), 1);
      chk("bad_opc_cnt", 32'(cnt), 3);
      in_inst = 32'h00AA8C30;
      tick();
      chk("bad_low_illegal", 32'(illegal), 1);
      chk("bad_low_cnt", 32'(cnt), 4);
      in_inst = 32'hFE209CE3; in_pc = 32'h130;
      tick();
      chk("bne_imm", imm, 32'hFFFFFFF8);
      chk("bne_alu_op", 32'(alu_op), 1);
      chk("bne_alu_ctrl", 32'(alu_ctrl), 1);
      chk("bne_illegal", 32'(illegal), 0);
      chk("bne_datab", 32'(datab), 0);

      in_inst = 32'h00000C67; in_pc = 32'h200;
      tick();
      out_ready = 1'b0; in_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 0);
      chk("async_rst_jal", 32'(jal), 0);
      chk("async_rst_pc", out_pc, 0);
      chk("async_rst_cnt", 32'(cnt), 0);
      chk("async_rst_in_ready", 32'(in_ready), 0);
      #2 rst_n = 1'b1;
      tick();
      chk("post_rst_valid", 32'(out_valid), 0);
      in_valid = 1'b1; out_ready = 1'b1; in_inst = 32'h00AA8C33; in_pc = 32'h300;
      tick();
      chk("resume_valid", 32'(out_valid), 1);
      chk("resume_pc", out_pc, 32'h300);
      in_valid = 1'b0;
      tick();
      chk("drain_valid", 32'(out_valid), 0);

      in_valid_m = 1'b1; in_inst = 32'h023100B3; in_pc = 32'h400;
      tick();
      chk("m_mul_alu_ctrl", 32'(alu_ctrl_m), 16);
      chk("m_mul_illegal", 32'(illegal_m), 0);
      chk("m_mul_reg_w", 32'(reg_w_m), 1);
      chk("m_mul_cnt", 32'(cnt_m), 0);
      in_inst = 32'h00AA8C33;
      tick();
      chk("e_add_illegal", 32'(illegal_m), 1);
      chk("e_add_cnt", 32'(cnt_m), 1);
      in_inst = 32'hFFFFFFFF;
      tick();
      chk("sat_cnt_2", 32'(cnt_m), 2);
      tick();
      chk("sat_cnt_3", 32'(cnt_m), 3);
      tick();
      chk("sat_hold_a", 32'(cnt_m), 3);
      tick();
      chk("sat_hold_b", 32'(cnt_m), 3);
      in_valid_m = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
